// File: rtl/versatile_fifo_rd_ctrl.sv
// versatile_fifo_rd_ctrl: read-side controller of the versatile FIFO with FWFT output
//
// Synchronises the write Gray pointer, issues RAM reads, absorbs the RAM's
// one-cycle registered-address latency in a 2-entry output buffer and
// returns the Gray read pointer to the write side.
//
// Ports:
//   clk           read-domain clock (also the RAM read clock)
//   rst           asynchronous, active-high reset
//   wptr_gray_i   write pointer, Gray coded, from the write domain
//   rptr_gray_o   read pointer, Gray coded, registered
//   ram_adr_o     RAM read address (RAM registers it on clk)
//   ram_q_i       RAM read data, valid the cycle after the address is registered
//   dout_o        head-of-FIFO word
//   dout_valid_o  dout_o holds a valid word
//   dout_ready_i  consumer accepts the head word
//   empty_o       nothing stored in the FIFO or the read pipeline
//   level_o       words visible to the read side (only with VERSATILE_FIFO_RD_LEVEL_EN)
//
// Optional feature macro: VERSATILE_FIFO_RD_LEVEL_EN
module versatile_fifo_rd_ctrl #(
    parameter int DATA_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 9,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH:0]   wptr_gray_i,
    output logic [ADDR_WIDTH:0]   rptr_gray_o,
    output logic [ADDR_WIDTH-1:0] ram_adr_o,
    input  logic [DATA_WIDTH-1:0] ram_q_i,
    output logic [DATA_WIDTH-1:0] dout_o,
    output logic                  dout_valid_o,
    input  logic                  dout_ready_i,
`ifdef VERSATILE_FIFO_RD_LEVEL_EN
    output logic [ADDR_WIDTH:0]   level_o,
`endif
    output logic                  empty_o
);
    function automatic logic [ADDR_WIDTH:0] gray2bin(input logic [ADDR_WIDTH:0] g);
        logic [ADDR_WIDTH:0] b;
        for (int i = 0; i <= ADDR_WIDTH; i++) b[i] = ^(g >> i);
        return b;
    endfunction

    logic [ADDR_WIDTH:0]   sync_q [SYNC_STAGES];
    logic [ADDR_WIDTH:0]   wptr_bin, wptr_bin_n, rptr, rptr_n;
    logic [1:0]            occ, occ_n, idx;
    logic [2:0]            need;
    logic                  pend, pop, issue, empty_int;
    logic [DATA_WIDTH-1:0] head_q, tail_q, head_n, tail_n;

    assign wptr_bin     = gray2bin(sync_q[SYNC_STAGES-1]);
    // value the last sync stage takes on the coming edge, so empty_o/level_o track the state exactly
    assign wptr_bin_n   = gray2bin(sync_q[SYNC_STAGES-2]);
    assign empty_int    = rptr == wptr_bin;
    assign pop          = dout_valid_o & dout_ready_i;
    // words held or in flight after this edge; issue only if one more still fits in the buffer
    assign need         = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};
    assign issue        = !empty_int && need < 3'd2;
    assign rptr_n       = rptr + {{ADDR_WIDTH{1'b0}}, issue};
    // slot the captured word lands in once the popped head has shifted out
    assign idx          = occ - {1'b0, pop};
    assign occ_n        = idx + {1'b0, pend};
    assign head_n       = (pend && idx == 2'd0) ? ram_q_i : pop ? tail_q : head_q;
    assign tail_n       = (pend && idx == 2'd1) ? ram_q_i : tail_q;
    assign ram_adr_o    = rptr[ADDR_WIDTH-1:0];
    assign dout_o       = head_q;
    assign dout_valid_o = occ != 2'd0;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
            rptr        <= '0;
            rptr_gray_o <= '0;
            pend        <= 1'b0;
            occ         <= 2'd0;
            head_q      <= '0;
            tail_q      <= '0;
            empty_o     <= 1'b1;
        end else begin
            sync_q[0] <= wptr_gray_i;
            for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
            rptr        <= rptr_n;
            rptr_gray_o <= rptr_n ^ (rptr_n >> 1);
            pend        <= issue;
            occ         <= occ_n;
            head_q      <= head_n;
            tail_q      <= tail_n;
            empty_o     <= rptr_n == wptr_bin_n && !issue && occ_n == 2'd0;
        end

`ifdef VERSATILE_FIFO_RD_LEVEL_EN
    always_ff @(posedge clk or posedge rst)
        if (rst)
            level_o <= '0;
        else
            level_o <= wptr_bin_n - rptr_n + {{(ADDR_WIDTH-1){1'b0}}, occ_n} + {{ADDR_WIDTH{1'b0}}, issue};
`endif
endmodule

// File: doc/versatile_fifo_rd_ctrl.md
Name: versatile_fifo_rd_ctrl

Overview:
Read-side controller for the versatile FIFO. It consumes the write-domain Gray pointer, synchronises it, and tracks the read pointer. It drives the read address of the dual-clock simple-write RAM, absorbs that RAM's one-cycle registered-address read latency, and presents data to the consumer as first-word-fall-through with a valid/ready handshake. It returns its own Gray read pointer to the write side for full detection.

Parameters:
DATA_WIDTH, 8, word width; matches the RAM data width.
ADDR_WIDTH, 9, RAM address width; FIFO depth is 2**ADDR_WIDTH.
SYNC_STAGES, 2, flop stages on the incoming write pointer (>=2).

Ports:
clk  in  1  read-domain clock (also drives the RAM read clock).
rst  in  1  asynchronous, active-high reset.
wptr_gray_i  in  ADDR_WIDTH+1  write pointer, Gray coded, from the write domain.
rptr_gray_o  out  ADDR_WIDTH+1  read pointer, Gray coded, registered.
ram_adr_o  out  ADDR_WIDTH  RAM read address; the RAM registers it on clk.
ram_q_i  in  DATA_WIDTH  RAM read data; valid one cycle after the address is registered.
dout_o  out  DATA_WIDTH  head-of-FIFO word.
dout_valid_o  out  1  dout_o holds a valid word.
dout_ready_i  in  1  consumer accepts; pop = dout_valid_o & dout_ready_i.
empty_o  out  1  no word stored anywhere in the FIFO or the read pipeline.

Behaviour:
- One clock. Reset is asynchronous and active-high. Every flop clears on rst assertion without waiting for a clock edge.
- Reset values:
  - rptr (binary) = 0 and rptr_gray_o = 0.
  - ram_adr_o = 0.
  - dout_o = 0, dout_valid_o = 0, empty_o = 1.
  - Synchroniser = 0, occ = 0, pend = 0.
- Synchroniser: wptr_gray_i passes through SYNC_STAGES flops. The last stage is Gray-decoded to wptr_bin.
- empty_int = (rptr == wptr_bin), full ADDR_WIDTH+1-bit compare. Wrap: both pointers roll from 2**(ADDR_WIDTH+1)-1 to 0, and the MSB difference distinguishes full from empty.
- ram_adr_o = rptr[ADDR_WIDTH-1:0], combinational from the rptr register.
- Output buffer: 2-entry FIFO of words, head entry driven onto dout_o.
  - occ = 0..2, number of entries held.
  - pend = 1 when a RAM read was issued in the previous cycle.
- Issue rule, evaluated each cycle:
  - issue = !empty_int & ((occ + pend - pop) < 2).
  - On issue, rptr increments by 1 and rptr_gray_o is updated from the new value.
  - The next cycle sets pend = 1.
- Capture: on the edge following a cycle with pend = 1, ram_q_i is written into the buffer tail.
  - Simultaneous capture and pop: occ is unchanged and the order is preserved.
  - Capture into an empty buffer, or pop of the last entry, updates the head the same edge.
- Throughput is 1 word/clk sustained while dout_ready_i = 1 and data is available.
- Latency: the first word's dout_valid_o rises after the (SYNC_STAGES+2)th rising edge following the wptr_gray_i change, i.e. SYNC_STAGES sync edges, the issue/RAM-address edge, and the capture edge.
- dout_valid_o = (occ != 0).
  - dout_o and dout_valid_o must not change while dout_valid_o = 1 and dout_ready_i = 0.
  - dout_ready_i is ignored while dout_valid_o = 0.
- empty_o = empty_int & !pend & (occ == 0), registered.
- Backpressure: with dout_ready_i held low, at most 2 words are prefetched (occ = 2, pend = 0). rptr then stops advancing.
- Reset mid-operation: buffered and pending words are discarded and rptr returns to 0. The write side must be reset concurrently.

Optional Feature:
VERSATILE_FIFO_RD_LEVEL_EN
- Defined:
  - Adds output port level_o, width ADDR_WIDTH+1, registered, reset value 0.
  - level_o = (wptr_bin - rptr) modulo 2**(ADDR_WIDTH+1), plus occ, plus pend.
  - It counts every stored word visible to the read side, with range 0..2**ADDR_WIDTH.
- Undefined: port and logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then 10 idle cycles -> empty_o = 1, dout_valid_o = 0, rptr_gray_o = 0, ram_adr_o = 0.
- Model writes 0xA5 at address 0 and drives wptr_gray_i = 1 -> dout_valid_o rises after edge SYNC_STAGES+2, dout_o = 0xA5, rptr_gray_o = 1. After one pop: empty_o = 1 and dout_valid_o = 0.
- Fill 16 words 0x00..0x0F with dout_ready_i = 1 -> one word per clk after initial latency, in order. rptr_gray_o ends at Gray(16) = 0x18.
- Fill 8 words with dout_ready_i = 0 for 20 cycles -> occ = 2 and rptr = 2, dout_o stays 0x00. Release ready -> 0x00..0x07 delivered in order, none lost.
- Preload rptr/wptr near 2**(ADDR_WIDTH+1)-1 (1022 for the default), stream 4 words across the wrap -> correct data, ram_adr_o wraps 511 -> 0, no spurious empty.
- Assert rst for 1 cycle mid-stream with occ = 2 -> outputs at reset values immediately. With VERSATILE_FIFO_RD_LEVEL_EN, level_o = 0.
